// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - nibble-serial ripple adder, one 4-bit nibble per clock
module nibble_serial_adder #(
  parameter  int NIB = 4,
  localparam int W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;

  logic [IW+1:0]   bit_base;
  logic [4:0]      nib_sum;
  logic            last_nib;

  assign bit_base = {idx_q, 2'b00};
  assign nib_sum  = {1'b0, a_q[bit_base +: 4]} + {1'b0, b_q[bit_base +: 4]} + {4'b0000, carry_q};
  assign last_nib = (idx_q == IW'(NIB - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        s_d[bit_base +: 4] = nib_sum[3:0];
        carry_d            = nib_sum[4];
        if (last_nib) begin
          // index parks at 0 so it never exceeds NIB-1 for non-power-of-two NIB
          cout_d  = nib_sum[4];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - scoreboard bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_q[$];
  logic [15:0] s_hist[0:31];
  logic        c_hist[0:31];
  int          lat;
  int          busy_cnt;
  int          done_cnt;

  nibble_serial_adder #(.NIB(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("sum", {15'd0, cout, s}, {15'd0, exp_q.pop_front()});
    end
  end

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic c, input bit push);
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    if (push) exp_q.push_back(model(x, y, c));
  endtask

  // Called at the negedge right after the accept edge; returns at done or after the bound.
  task automatic wait_done();
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      s_hist[lat] = s;
      c_hist[lat] = cout;
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    s_hist[lat] = s;
    c_hist[lat] = cout;
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    drive(x, y, c, 1'b1);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
    wait_done();
  endtask

  initial begin
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ignores_start", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst = 1'b0;

    run_op(16'h0000, 16'h0000, 1'b0);
    check("zero_latency", lat, 4);

    run_op(16'hFFFF, 16'h0001, 1'b0);
    check("ripple_latency", lat, 4);
    check("ripple_busy_cycles", busy_cnt, 4);
    check("ripple_cout_during_run", {31'd0, c_hist[3]}, 32'd0);

    run_op(16'h1234, 16'h4321, 1'b1);
    check("inter_s0", {16'd0, s_hist[0]}, 32'h0000);
    check("inter_s1", {16'd0, s_hist[1]}, 32'h0006);
    check("inter_s2", {16'd0, s_hist[2]}, 32'h0056);
    check("inter_s3", {16'd0, s_hist[3]}, 32'h0556);
    check("inter_s4", {16'd0, s_hist[4]}, 32'h5556);
    @(negedge clk);
    check("hold_s_idle", {16'd0, s}, 32'h5556);
    check("idle_done_low", {31'd0, done}, 32'd0);

    // start during RUN must be ignored
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ignore_start_latency", lat, 3);
    check("ignore_start_s", {16'd0, s}, 32'h0100);

    // reset mid-RUN aborts without a done pulse
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_abort_s", {16'd0, s}, 32'h0033);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_s", {16'd0, s}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    run_op(16'h8000, 16'h8000, 1'b0);
    check("post_abort_cout", {31'd0, cout}, 32'd1);
    check("post_abort_s", {16'd0, s}, 32'd0);

    // back-to-back: start held through DONE
    @(negedge clk);
    drive(16'h0005, 16'h0006, 1'b0, 1'b1);
    @(negedge clk);
    drive(16'h0001, 16'h0002, 1'b0, 1'b1);
    wait_done();
    check("b2b_first_latency", lat, 4);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    wait_done();
    check("b2b_second_latency", lat, 4);
    check("b2b_s", {16'd0, s}, 32'h0003);

    for (int i = 0; i < 10000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom));
      if (lat != 4) check("rand_latency", lat, 4);
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to add; accepted only when busy=0.
REQ-006 a  input  W  operand A, sampled on the accept edge only.
REQ-007 b  input  W  operand B, sampled on the accept edge only.
REQ-008 cin  input  1  carry-in, sampled on the accept edge only.
REQ-009 busy  output  1  high while nibbles are being processed.
REQ-010 done  output  1  one-cycle pulse: s/cout valid.
REQ-011 s  output  W  sum, registered.
REQ-012 cout  output  1  final carry-out, registered.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both SHALL be decoded from state.
REQ-015 Accept edge: rising clk with start=1 in IDLE or DONE.
- captures a, b into internal regs; carry reg <= cin; nibble index <= 0; s <= 0; cout <= 0; state <= RUN.
REQ-016 start=1 in RUN SHALL be ignored; captured operands, index and carry SHALL NOT change.
REQ-017 Each RUN edge SHALL process nibble idx, least-significant nibble first:
- {c, sum4} = a[idx] + b[idx] + carry.
- s[4*idx+3:4*idx] <= sum4; carry <= c; idx <= idx+1.
REQ-018 On the RUN edge that processes idx = NIB-1, the block SHALL also do: cout <= c; state <= DONE.
REQ-019 Latency: done SHALL be high exactly NIB cycles after the accept edge; RUN SHALL last exactly NIB cycles.
REQ-020 DONE SHALL last exactly one cycle, then go to IDLE, unless start=1 on that edge, in which case it SHALL go to RUN (back-to-back accept).
REQ-021 s and cout SHALL hold their final values through DONE and IDLE until the next accept edge.
REQ-022 During RUN, s SHALL show the nibbles completed so far and zeros above them; cout SHALL read 0.
REQ-023 Arithmetic is unsigned modulo 2^W; {cout, s} SHALL equal a + b + cin for all operand values.
REQ-024 The nibble index SHALL be ceil(log2(NIB)) bits wide (minimum 1) and SHALL never exceed NIB-1.
REQ-025 a, b and cin SHALL be don't-care except on the accept edge.

Reset
REQ-026 Asserting rst SHALL immediately, without a clock edge, force: state=IDLE, busy=0, done=0, s=0, cout=0, carry=0, idx=0, captured operands=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL occur for the aborted add.
REQ-028 While rst=1, start SHALL be ignored; the first accept is possible on the first rising edge after rst deasserts.

Verification
REQ-029 a=0x0000, b=0x0000, cin=0 -> done exactly 4 cycles after accept; s=0x0000, cout=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 nibbles; s=0x0000, cout=1; busy high for exactly 4 cycles.
REQ-031 a=0x1234, b=0x4321, cin=1 -> s=0x5556, cout=0.
- Intermediate s after the RUN edges: 0x0006, 0x0056, 0x0556, 0x5556.
REQ-032 Accept a=0x00FF, b=0x0001, cin=0; one cycle later pulse start with a=0xFFFF, b=0xFFFF -> second start ignored; result s=0x0100, cout=0.
REQ-033 Assert rst 2 cycles into RUN -> busy, s and cout drop to 0 immediately; no done pulse.
- Then start a=0x8000, b=0x8000, cin=0 -> s=0x0000, cout=1.
REQ-034 Back-to-back: start held high through DONE with new operands a=0x0001, b=0x0002 -> RUN re-entered with no IDLE cycle; second done exactly 4 cycles later; s=0x0003, cout=0.
REQ-035 Random regression of at least 10k operand pairs -> {cout, s} matches a + b + cin on every done pulse.
